secuencial_01_core: RTL and testbench
=====================================

// Module: secuencial_01_core
//
// PURPOSE
// - Registered, enable-gated selector: on each clk rising edge with enable=1,
//   captures one of three 1-bit inputs (a, b, c), or their majority, into z.
// - z holds its value while enable=0.
// - Used as a small sequential leaf (flag/state bit) beneath control logic.
//
// PARAMETERS
// - RST_VAL  1'b0  value loaded into z on reset
//
// PORTS
// - clk     in   1  rising-edge clock; single clock domain
// - rst     in   1  reset, asynchronous, active-high
// - sel     in   2  source select: 0=a, 1=b, 2=c, 3=majority(a,b,c)
// - enable  in   1  capture enable; 1 = load z at next edge, 0 = hold
// - a       in   1  data input 0
// - b       in   1  data input 1
// - c       in   1  data input 2
// - z       out  1  registered output
//
// BEHAVIOUR
// - Reset:
//   - rst=1 forces z=RST_VAL immediately, with no clock edge needed.
//   - z stays at RST_VAL for as long as rst=1; inputs are ignored.
//   - Release is synchronous to the logic: the first load occurs on the first
//     rising edge after rst falls where enable=1.
// - Next-state function, evaluated at each rising clk edge with rst=0:
//   - enable=1: z <= mux(sel), where
//     - sel=0 -> a
//     - sel=1 -> b
//     - sel=2 -> c
//     - sel=3 -> (a&b)|(a&c)|(b&c)
//   - enable=0: z <= z (hold).
// - Latency: exactly 1 cycle from inputs sampled at an edge to z.
//   - No combinational path from any input to z.
// - Timing: sel, enable, a, b and c are sampled only at the rising edge.
//   - Glitches or changes between edges have no effect.
//   - Changing sel and enable together with data is legal; the values present
//     at the edge are used.
// - Reset mid-operation: z goes to RST_VAL asynchronously; there is no pending
//   state to flush.
// - X-handling: sel must never be X when enable=1.
//   - The verification bench asserts this.
//   - The RTL uses a default branch equal to sel=0.
// - Not a handshake block: there is no ready/valid, and there is no
//   backpressure.
//
// STRUCTURE
// - Package secuencial_pkg:
//   - typedef enum logic [1:0] sel_t {SEL_A, SEL_B, SEL_C, SEL_MAJ}
//   - localparam RST_VAL_DEFAULT = 1'b0
// - Sub-module sec_mux4 (purely combinational):
//   - inputs sel, a, b, c; output d
//   - implements the selection and majority function
// - Top:
//   - one always_ff with asynchronous reset (posedge clk or posedge rst)
//   - uses the enable-gated load of d
//
// TESTING
// 1. Reset:
//    - rst=1 for 3 cycles with a=b=c=1, enable=1 -> z=0 throughout.
//    - rst asserted mid-cycle -> z=0 before the next edge.
// 2. Hold:
//    - rst=0, enable=0, sel=0; toggle a 0->1->0 over 4 cycles -> z stays 0.
// 3. Load a:
//    - enable=1, sel=0, a=1 -> z=1 exactly one edge later.
//    - a=0 -> z=0 at the following edge.
// 4. Select sweep:
//    - a=1, b=0, c=1, enable=1.
//    - sel=0,1,2,3 on successive cycles -> z = 1,0,1,1, each delayed one cycle.
// 5. Majority:
//    - sel=3; (a,b,c) = 110, 100, 011, 001 -> z = 1,0,1,0.
// 6. Enable drop:
//    - After z=1, set enable=0 and a=b=c=0 for 3 cycles -> z stays 1.
//    - Re-enable with sel=0 -> z=0 next edge.

Source files
------------

// File: rtl/secuencial_pkg.sv
// Shared types and constants for the enable-gated selector flop.
package secuencial_pkg;

  typedef enum logic [1:0] {
    SEL_A   = 2'd0,
    SEL_B   = 2'd1,
    SEL_C   = 2'd2,
    SEL_MAJ = 2'd3
  } sel_t;

  localparam logic RST_VAL_DEFAULT = 1'b0;

endpackage

// File: rtl/sec_mux4.sv
// Combinational source select: one of a/b/c, or the 2-of-3 majority.
module sec_mux4
  import secuencial_pkg::*;
(
  input  sel_t sel,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d
);

  always_comb begin
    d = a;
    case (sel)
      SEL_A:   d = a;
      SEL_B:   d = b;
      SEL_C:   d = c;
      SEL_MAJ: d = (a & b) | (a & c) | (b & c);
      // An unknown select falls back to the a path.
      default: d = a;
    endcase
  end

endmodule

// File: rtl/secuencial_01_core.sv
// Registered selector: z loads the muxed source when enable is high, else holds.
module secuencial_01_core
  import secuencial_pkg::*;
#(
  parameter logic RST_VAL = RST_VAL_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic       enable,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       z
);

  logic d;

  sec_mux4 u_mux (
    .sel (sel_t'(sel)),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         z <= RST_VAL;
    else if (enable) z <= d;
  end

endmodule

// File: tb/tb_secuencial_01_core.sv
// Directed plus randomized checks of the selector flop against a reference model.
module tb_secuencial_01_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       enable;
  logic       a, b, c;
  logic       z;

  int  n_pass  = 0;
  int  n_total = 0;
  logic exp_z  = 1'b0;

  secuencial_01_core #(.RST_VAL(1'b0)) dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .enable (enable),
    .a      (a),
    .b      (b),
    .c      (c),
    .z      (z)
  );

  always #5 clk = ~clk;

  // sel must be known whenever a load can happen
  always @(posedge clk)
    if (rst === 1'b0 && enable === 1'b1)
      assert (!$isunknown(sel)) else $error("FAIL sel_x observed=%b expected=known", sel);

  // Reference: pick the indexed input, or the 2-of-3 vote for select 3.
  function automatic logic ref_pick(input int s, input logic ia, input logic ib, input logic ic);
    logic src [3];
    src[0] = ia; src[1] = ib; src[2] = ic;
    if (s == 3) return ((int'(ia) + int'(ib) + int'(ic)) >= 2);
    return src[s];
  endfunction

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
  endtask

  // One clock: update the model at the edge, return at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) exp_z = 1'b0;
    else if (enable) exp_z = ref_pick(int'(sel), a, b, c);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] s, input logic en, input logic ia, input logic ib, input logic ic);
    sel = s; enable = en; a = ia; b = ib; c = ic;
  endtask

  initial begin
    logic [3:0] exp_sweep;
    logic [3:0] exp_maj;
    logic [2:0] maj_in [4];
    rst = 1'b1;
    drive(2'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    #1 chk("reset_async_init", z, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("reset_hold", z, 1'b0);
    end

    // hold with enable low while a toggles
    rst = 1'b0;
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = i[0];
      cycle();
      chk("hold_en0", z, 1'b0);
    end

    drive(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(); chk("load_a1", z, 1'b1);
    a = 1'b0;
    cycle(); chk("load_a0", z, 1'b0);

    exp_sweep = 4'b1101; // z for sel=3..0
    drive(2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      cycle();
      chk("sel_sweep", z, exp_sweep[s]);
    end

    maj_in[0] = 3'b110; maj_in[1] = 3'b100; maj_in[2] = 3'b011; maj_in[3] = 3'b001;
    exp_maj = 4'b0101; // bit i is the result for maj_in[i]
    for (int i = 0; i < 4; i++) begin
      drive(2'd3, 1'b1, maj_in[i][2], maj_in[i][1], maj_in[i][0]);
      cycle();
      chk("majority", z, exp_maj[i]);
    end

    drive(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(); chk("en_drop_load", z, 1'b1);
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("en_drop_hold", z, 1'b1);
    end
    enable = 1'b1;
    cycle(); chk("re_enable", z, 1'b0);

    // reset asserted between edges must clear z without a clock
    drive(2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(); chk("pre_midreset", z, 1'b1);
    #2 rst = 1'b1;
    #1 chk("reset_midcycle", z, 1'b0);
    cycle(); chk("reset_mid_hold", z, 1'b0);
    rst = 1'b0;

    // randomized traffic with occasional async reset pulses
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      rst = ($urandom_range(0, 19) == 0);
      if (rst) begin
        exp_z = 1'b0;
        #1 chk("rand_async_rst", z, exp_z);
      end
      cycle();
      chk("rand_model", z, exp_z);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
